// File: rtl/mem_arb_sram_if.sv
// Shared-memory request bus: per-port valid/ready handshake with packed address,
// write data, byte strobes, read data and error flags.
interface mem_arb_sram_if #(
  parameter int NUM_PORTS = 2
);
  logic [NUM_PORTS-1:0]    mem_valid;
  logic [NUM_PORTS-1:0]    mem_ready;
  logic [32*NUM_PORTS-1:0] mem_addr;
  logic [32*NUM_PORTS-1:0] mem_wdata;
  logic [4*NUM_PORTS-1:0]  mem_wstrb;
  logic [32*NUM_PORTS-1:0] mem_rdata;
  logic [NUM_PORTS-1:0]    mem_err;

  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata, mem_err
  );

  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata, mem_err
  );
endinterface

// File: rtl/mem_arb_sram.sv
// N-port shared word memory: round-robin arbitration, byte-strobe writes,
// programmable wait states, out-of-range error responses.
module mem_arb_sram #(
  parameter int NUM_PORTS   = 2,
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 0,
  parameter int IDX_W       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  mem_arb_sram_if.slave    bus,
  output logic             busy,
  output logic [IDX_W-1:0] grant_idx
);
  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]              state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [IDX_W-1:0]        rr_ptr_q, gnt_q;
  logic [31:0]             addr_q, wdata_q;
  logic [3:0]              wstrb_q;
  logic [NUM_PORTS-1:0]    ready_q, err_q;
  logic [32*NUM_PORTS-1:0] rdata_q;
  logic [31:0]             mem_q [DEPTH_WORDS];

  logic                    any_req;
  logic [IDX_W-1:0]        win, cand;
  logic                    do_access, in_range;
  logic [IDX_W-1:0]        acc_g;
  logic [31:0]             acc_addr, acc_wdata;
  logic [3:0]              acc_wstrb;
  logic [AW-1:0]           acc_word;

  // Round-robin pick: first requesting port at or after rr_ptr, wrapping.
  always_comb begin
    any_req = 1'b0;
    win     = rr_ptr_q;
    cand    = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      cand = IDX_W'((32'(rr_ptr_q) + i) % 32'(NUM_PORTS));
      if (!any_req && bus.mem_valid[cand]) begin
        any_req = 1'b1;
        win     = cand;
      end
    end
  end

  // Access operands: live winner when accessing straight from IDLE, latched copy otherwise.
  always_comb begin
    if (state_q == ST_IDLE) begin
      acc_g     = win;
      acc_addr  = bus.mem_addr[32*win +: 32];
      acc_wdata = bus.mem_wdata[32*win +: 32];
      acc_wstrb = bus.mem_wstrb[4*win +: 4];
    end else begin
      acc_g     = gnt_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_wstrb = wstrb_q;
    end
    do_access = ((state_q == ST_IDLE) && any_req && (WAIT_STATES == 0)) ||
                ((state_q == ST_WAIT) && (cnt_q == '0));
    in_range  = (acc_addr >> 2) < 32'(DEPTH_WORDS);
    acc_word  = acc_addr[AW+1:2];
  end

  // Next-state and wait-counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: if (any_req) begin
        if (WAIT_STATES == 0) begin
          state_d = ST_RESP;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = 4'(WAIT_STATES - 1);
        end
      end
      ST_WAIT: if (cnt_q == '0) state_d = ST_RESP;
               else             cnt_d   = cnt_q - 4'd1;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Control registers, grant latch and per-port response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      ready_q  <= '0;
      err_q    <= '0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= '0;
      err_q   <= '0;
      if (state_q == ST_IDLE && any_req) begin
        gnt_q   <= win;
        addr_q  <= acc_addr;
        wdata_q <= acc_wdata;
        wstrb_q <= acc_wstrb;
      end
      if (do_access) begin
        ready_q[acc_g]          <= 1'b1;
        err_q[acc_g]            <= !in_range;
        rdata_q[32*acc_g +: 32] <= in_range ? mem_q[acc_word] : '0;
        rr_ptr_q <= (32'(acc_g) + 1 == 32'(NUM_PORTS)) ? '0 : acc_g + 1'b1;
      end
    end
  end

  // Array write: contents survive reset; an access coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (!reset && do_access && in_range) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (acc_wstrb[b]) mem_q[acc_word][8*b +: 8] <= acc_wdata[8*b +: 8];
      end
    end
  end

  assign bus.mem_ready = ready_q;
  assign bus.mem_err   = err_q;
  assign bus.mem_rdata = rdata_q;
  assign busy          = (state_q != ST_IDLE);
  assign grant_idx     = gnt_q;
endmodule

// File: tb/tb_mem_arb_sram.sv
// Randomized bench for mem_arb_sram: a 2-port zero-wait instance and a 4-port
// three-wait-state instance, both checked every cycle against a transaction model.
module tb_mem_arb_sram;
  localparam int DEPTH  = 256;
  localparam int CYCLES = 6000;
  localparam int NDIR   = 6;

  function automatic int np(input int d); return (d == 0) ? 2 : 4; endfunction
  function automatic int wsn(input int d); return (d == 0) ? 0 : 3; endfunction
  function automatic logic [31:0] init_val(input int k);
    if (k == 100) return 32'h0201_0201;
    if (k == 104) return 32'h0000_0703;
    return {16'hC0DE, 16'(k)};
  endfunction

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Requester-side drive and DUT-side observation, indexed [instance][port].
  logic        v   [2][4];
  logic [31:0] a   [2][4];
  logic [31:0] wd  [2][4];
  logic [3:0]  wsb [2][4];
  logic [31:0] rd_o [2][4];
  logic [3:0]  rdy_o [2];
  logic [3:0]  err_o [2];
  logic        busy_o [2];
  logic [1:0]  gnt_o [2];

  logic       busy_a, busy_b;
  logic [0:0] gnt_a;
  logic [1:0] gnt_b;

  mem_arb_sram_if #(.NUM_PORTS(2)) bus_a ();
  mem_arb_sram_if #(.NUM_PORTS(4)) bus_b ();

  mem_arb_sram #(.NUM_PORTS(2), .DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut_a (
    .clk(clk), .reset(rst), .bus(bus_a), .busy(busy_a), .grant_idx(gnt_a));
  mem_arb_sram #(.NUM_PORTS(4), .DEPTH_WORDS(DEPTH), .WAIT_STATES(3)) dut_b (
    .clk(clk), .reset(rst), .bus(bus_b), .busy(busy_b), .grant_idx(gnt_b));

  for (genvar p = 0; p < 2; p++) begin : g_a
    assign bus_a.mem_valid[p]         = v[0][p];
    assign bus_a.mem_addr[32*p +: 32]  = a[0][p];
    assign bus_a.mem_wdata[32*p +: 32] = wd[0][p];
    assign bus_a.mem_wstrb[4*p +: 4]   = wsb[0][p];
    assign rd_o[0][p] = bus_a.mem_rdata[32*p +: 32];
  end
  for (genvar p = 2; p < 4; p++) begin : g_a_pad
    assign rd_o[0][p] = '0;
  end
  for (genvar p = 0; p < 4; p++) begin : g_b
    assign bus_b.mem_valid[p]         = v[1][p];
    assign bus_b.mem_addr[32*p +: 32]  = a[1][p];
    assign bus_b.mem_wdata[32*p +: 32] = wd[1][p];
    assign bus_b.mem_wstrb[4*p +: 4]   = wsb[1][p];
    assign rd_o[1][p] = bus_b.mem_rdata[32*p +: 32];
  end
  assign rdy_o[0]  = {2'b00, bus_a.mem_ready};
  assign err_o[0]  = {2'b00, bus_a.mem_err};
  assign rdy_o[1]  = bus_b.mem_ready;
  assign err_o[1]  = bus_b.mem_err;
  assign busy_o[0] = busy_a;
  assign busy_o[1] = busy_b;
  assign gnt_o[0]  = {1'b0, gnt_a};
  assign gnt_o[1]  = gnt_b;

  // Reference model: memory image plus transaction timing per instance.
  logic [31:0] mem_m   [2][DEPTH];
  bit          known_m [2][DEPTH];
  int          idle_from [2];
  bit          pend [2];
  int          acc_e [2];
  int          pg [2];
  logic [31:0] p_addr [2];
  logic [31:0] p_wd [2];
  logic [3:0]  p_ws [2];
  int          rr [2];
  int          gnt_m [2];
  logic [3:0]  exp_rdy [2];
  logic [3:0]  exp_err [2];
  bit          exp_busy [2];
  logic [31:0] exp_rd [2][4];
  bit          rd_known [2][4];
  bit          req [2][4];
  int          init_k [2];

  // Directed transactions on the 2-port instance once its array is loaded.
  int          d_port  [NDIR] = '{1, 0, 0, 1, 0, 0};
  logic [31:0] d_addr  [NDIR] = '{32'd400, 32'd416, 32'd416, 32'd1024, 32'd1024, 32'd0};
  logic [31:0] d_wdata [NDIR] = '{32'h0, 32'hAABB_CCDD, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0};
  logic [3:0]  d_wstrb [NDIR] = '{4'h0, 4'h3, 4'h0, 4'h0, 4'hF, 4'h0};
  logic [31:0] d_exp   [NDIR] = '{32'h0201_0201, 32'h0000_0703, 32'h0000_CCDD,
                                  32'h0, 32'h0, 32'hC0DE_0000};
  logic        d_err   [NDIR] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  int          dir_i = 0;
  bit          dir_busy = 0;
  int          dir_cur = 0;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One clock edge of the model for instance d, using the inputs held across it.
  task automatic model_edge(input int d, input int e);
    int g;
    logic [31:0] w;
    exp_rdy[d] = '0;
    exp_err[d] = '0;
    if (rst) begin
      pend[d]      = 0;
      idle_from[d] = e + 1;
      rr[d]        = 0;
      gnt_m[d]     = 0;
      for (int p = 0; p < 4; p++) begin exp_rd[d][p] = '0; rd_known[d][p] = 1; end
    end else begin
      if (idle_from[d] <= e) begin
        g = -1;
        for (int k = 0; k < np(d); k++)
          if (g < 0 && v[d][(rr[d] + k) % np(d)]) g = (rr[d] + k) % np(d);
        if (g >= 0) begin
          pg[d] = g; gnt_m[d] = g;
          p_addr[d] = a[d][g]; p_wd[d] = wd[d][g]; p_ws[d] = wsb[d][g];
          pend[d] = 1;
          acc_e[d] = e + wsn(d);
          idle_from[d] = e + wsn(d) + 2;
        end
      end
      if (pend[d] && acc_e[d] == e) begin
        pend[d] = 0;
        exp_rdy[d][pg[d]] = 1'b1;
        rr[d] = (pg[d] + 1) % np(d);
        if (p_addr[d] / 4 < DEPTH) begin
          w = p_addr[d] / 4;
          exp_rd[d][pg[d]]   = mem_m[d][w];
          rd_known[d][pg[d]] = known_m[d][w];
          for (int b = 0; b < 4; b++)
            if (p_ws[d][b]) mem_m[d][w][8*b +: 8] = p_wd[d][8*b +: 8];
          if (p_ws[d] == 4'hF) known_m[d][w] = 1;
        end else begin
          exp_rd[d][pg[d]]   = '0;
          rd_known[d][pg[d]] = 1;
          exp_err[d][pg[d]]  = 1'b1;
        end
      end
    end
    exp_busy[d] = (e + 1 < idle_from[d]);
  endtask

  task automatic compare(input int d);
    check_eq($sformatf("ready[%0d]", d), 32'(rdy_o[d]), 32'(exp_rdy[d]));
    check_eq($sformatf("err[%0d]", d), 32'(err_o[d]), 32'(exp_err[d]));
    check_eq($sformatf("busy[%0d]", d), 32'(busy_o[d]), 32'(exp_busy[d]));
    check_eq($sformatf("grant[%0d]", d), 32'(gnt_o[d]), 32'(gnt_m[d]));
    for (int p = 0; p < np(d); p++)
      if (rd_known[d][p]) check_eq($sformatf("rdata[%0d][%0d]", d, p), rd_o[d][p], exp_rd[d][p]);
  endtask

  task automatic drive(input int d);
    bit rand_ok, none;
    none = 1;
    for (int p = 0; p < np(d); p++) begin
      if (exp_rdy[d][p]) req[d][p] = 0;
      if (req[d][p]) none = 0;
    end
    if (d == 0 && init_k[0] == DEPTH && dir_i < NDIR && none && !dir_busy) begin
      req[0][d_port[dir_i]] = 1;
      a[0][d_port[dir_i]]   = d_addr[dir_i];
      wd[0][d_port[dir_i]]  = d_wdata[dir_i];
      wsb[0][d_port[dir_i]] = d_wstrb[dir_i];
      dir_cur = dir_i; dir_busy = 1; dir_i++;
    end
    rand_ok = (init_k[d] == DEPTH) && (d == 1 || (dir_i == NDIR && !dir_busy));
    for (int p = 0; p < np(d); p++) begin
      if (!req[d][p]) begin
        if (p == 0 && init_k[d] < DEPTH) begin
          req[d][p] = 1; a[d][p] = 32'(init_k[d] * 4);
          wd[d][p] = init_val(init_k[d]); wsb[d][p] = 4'hF;
          init_k[d]++;
        end else if (rand_ok && $urandom_range(0, 1) == 1) begin
          req[d][p] = 1;
          a[d][p]   = ($urandom_range(0, 9) == 0) ? 32'(1024 + $urandom_range(0, 4095))
                                                  : 32'($urandom_range(0, 1023));
          wd[d][p]  = $urandom;
          wsb[d][p] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'h0;
        end
      end
      v[d][p] = req[d][p];
      // The granted port's inputs are not looked at while its access is in flight.
      if (rand_ok && pend[d] && p == pg[d] && $urandom_range(0, 3) == 0) begin
        v[d][p] = 1'($urandom_range(0, 1));
        a[d][p] = $urandom;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      idle_from[d] = 0; pend[d] = 0; rr[d] = 0; gnt_m[d] = 0; init_k[d] = 0;
      for (int p = 0; p < 4; p++) begin
        v[d][p] = 1'b0; a[d][p] = '0; wd[d][p] = '0; wsb[d][p] = '0; req[d][p] = 0;
        exp_rd[d][p] = '0; rd_known[d][p] = 0;
      end
      for (int k = 0; k < DEPTH; k++) begin mem_m[d][k] = '0; known_m[d][k] = 0; end
    end
    for (int cyc = 0; cyc < CYCLES; cyc++) begin
      @(posedge clk);
      for (int d = 0; d < 2; d++) model_edge(d, cyc);
      @(negedge clk);
      for (int d = 0; d < 2; d++) compare(d);
      if (dir_busy && exp_rdy[0][d_port[dir_cur]]) begin
        check_eq($sformatf("dir_rdata[%0d]", dir_cur), rd_o[0][d_port[dir_cur]], d_exp[dir_cur]);
        check_eq($sformatf("dir_err[%0d]", dir_cur), 32'(err_o[0][d_port[dir_cur]]),
                 32'(d_err[dir_cur]));
        dir_busy = 0;
      end
      for (int d = 0; d < 2; d++) drive(d);
      rst = (cyc < 2) || (cyc > 1500 && $urandom_range(0, 99) == 0);
    end
    check_eq("directed_done", 32'(dir_i), 32'(NDIR));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
